// File: rtl/vc_test_src_arbiter.sv
// Round-robin arbiter that funnels several val/rdy test sources into one sink.
// A requester can keep the grant for a bounded burst. Every forwarded message
// is tagged with the index of its source and held in a one-entry output stage.
module vc_test_src_arbiter #(
    parameter int p_msg_nbits = 8,
    parameter int p_num_reqs  = 4,
    parameter int p_max_burst = 4,
    localparam int c_tag_nbits = $clog2(p_num_reqs)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [p_num_reqs-1:0]               in_val,
    output logic [p_num_reqs-1:0]               in_rdy,
    input  logic [p_num_reqs*p_msg_nbits-1:0]   in_msg,
    input  logic [p_num_reqs-1:0]               in_done,
    output logic                                out_val,
    input  logic                                out_rdy,
    output logic [c_tag_nbits+p_msg_nbits-1:0]  out_msg,
    output logic [31:0]                         xfer_count,
    output logic                                all_done
);

    localparam int c_burst_nbits = $clog2(p_max_burst + 1);
    localparam logic [c_tag_nbits-1:0]   c_last_idx  = c_tag_nbits'(p_num_reqs - 1);
    localparam logic [c_burst_nbits-1:0] c_max_burst = c_burst_nbits'(p_max_burst);

    logic                               out_val_q,    out_val_d;
    logic [c_tag_nbits+p_msg_nbits-1:0] out_msg_q,    out_msg_d;
    logic [c_tag_nbits-1:0]             ptr_q,        ptr_d;
    logic                               locked_q,     locked_d;
    logic [c_tag_nbits-1:0]             owner_q,      owner_d;
    logic [c_burst_nbits-1:0]           burst_cnt_q,  burst_cnt_d;
    logic [31:0]                        xfer_count_q, xfer_count_d;

    logic [c_tag_nbits-1:0]   gnt_idx;
    logic                     gnt_any;
    logic [c_tag_nbits-1:0]   scan_base;
    logic [c_tag_nbits-1:0]   scan_idx;
    int                       scan_pos;
    logic                     can_accept;
    logic                     xfer;
    logic [c_burst_nbits-1:0] burst_next;

    function automatic logic [c_tag_nbits-1:0] wrap_inc(input logic [c_tag_nbits-1:0] idx);
        return (idx == c_last_idx) ? '0 : idx + 1'b1;
    endfunction

    // Grant selection: a live lock keeps its owner, otherwise scan upward from the base.
    always_comb begin
        gnt_idx   = '0;
        gnt_any   = 1'b0;
        scan_pos  = 0;
        scan_idx  = '0;
        scan_base = locked_q ? wrap_inc(owner_q) : ptr_q;
        if (locked_q && in_val[owner_q]) begin
            gnt_idx = owner_q;
            gnt_any = 1'b1;
        end else begin
            // Walk from the far end so the closest valid requester wins last.
            for (int k = p_num_reqs - 1; k >= 0; k--) begin
                scan_pos = int'(scan_base) + k;
                if (scan_pos >= p_num_reqs) scan_pos = scan_pos - p_num_reqs;
                scan_idx = c_tag_nbits'(scan_pos);
                if (in_val[scan_idx]) begin
                    gnt_idx = scan_idx;
                    gnt_any = 1'b1;
                end
            end
        end
    end

    assign can_accept = !out_val_q || out_rdy;
    assign xfer       = gnt_any && can_accept && reset;

    // Next-state for the output stage, transfer counter and arbitration state.
    always_comb begin
        out_val_d    = out_val_q;
        out_msg_d    = out_msg_q;
        ptr_d        = ptr_q;
        locked_d     = locked_q;
        owner_d      = owner_q;
        burst_cnt_d  = burst_cnt_q;
        xfer_count_d = xfer_count_q;
        burst_next   = c_burst_nbits'(1);

        if (out_val_q && out_rdy) xfer_count_d = xfer_count_q + 32'd1;

        if (xfer) begin
            out_val_d = 1'b1;
            out_msg_d = {gnt_idx, in_msg[int'(gnt_idx)*p_msg_nbits +: p_msg_nbits]};
            if (locked_q && gnt_idx == owner_q) burst_next = burst_cnt_q + c_burst_nbits'(1);
            if (burst_next == c_max_burst) begin
                locked_d    = 1'b0;
                ptr_d       = wrap_inc(gnt_idx);
                burst_cnt_d = '0;
            end else begin
                locked_d    = 1'b1;
                owner_d     = gnt_idx;
                burst_cnt_d = burst_next;
            end
        end else begin
            if (out_val_q && out_rdy) out_val_d = 1'b0;
            // Owner went idle: give up the lock and restart the scan just past it.
            if (locked_q && !in_val[owner_q]) begin
                locked_d    = 1'b0;
                ptr_d       = wrap_inc(owner_q);
                burst_cnt_d = '0;
            end
        end
    end

    // State register with synchronous active-low reset; a reset edge drops any buffered message.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_val_q    <= 1'b0;
            out_msg_q    <= '0;
            ptr_q        <= '0;
            locked_q     <= 1'b0;
            owner_q      <= '0;
            burst_cnt_q  <= '0;
            xfer_count_q <= '0;
        end else begin
            out_val_q    <= out_val_d;
            out_msg_q    <= out_msg_d;
            ptr_q        <= ptr_d;
            locked_q     <= locked_d;
            owner_q      <= owner_d;
            burst_cnt_q  <= burst_cnt_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    // Outputs: one-hot ready toward the granted source, registered message side.
    always_comb begin
        in_rdy = '0;
        if (xfer) in_rdy[gnt_idx] = 1'b1;
    end

    assign out_val    = out_val_q;
    assign out_msg    = out_msg_q;
    assign xfer_count = xfer_count_q;
    assign all_done   = reset && (&in_done) && !out_val_q;

endmodule

// File: tb/tb_vc_test_src_arbiter.sv
// Randomized bench for vc_test_src_arbiter against a behavioural model of the
// arbitration rules (4 requesters, 8-bit payloads, bursts of up to 4).
module tb_vc_test_src_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic          clk;
    logic          reset;
    logic [N-1:0]  in_val;
    logic [N-1:0]  in_rdy;
    logic [N*W-1:0] in_msg;
    logic [N-1:0]  in_done;
    logic          out_val;
    logic          out_rdy;
    logic [W+1:0]  out_msg;
    logic [31:0]   xfer_count;
    logic          all_done;

    vc_test_src_arbiter #(
        .p_msg_nbits (W),
        .p_num_reqs  (N),
        .p_max_burst (BURST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_msg     (in_msg),
        .in_done    (in_done),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_msg    (out_msg),
        .xfer_count (xfer_count),
        .all_done   (all_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Model state: which requester the arbiter favours and what the sink side holds.
    int          m_ptr, m_owner, m_burst;
    bit          m_locked, m_oval, m_known;
    logic [W+1:0] m_omsg;
    int unsigned m_cnt;

    function automatic int pick(input logic [N-1:0] v);
        int start;
        if (m_locked && v[m_owner]) return m_owner;
        start = m_locked ? (m_owner + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
            if (v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    // One cycle: check registered outputs, apply inputs, check combinational outputs, advance model.
    task automatic step(input bit rst_n, input logic [N-1:0] v, input logic [N*W-1:0] msgs,
                        input logic [N-1:0] d, input bit ordy, output int g_out);
        int g, n;
        bit can;
        logic [N-1:0] rdy_exp;
        if (m_known) begin
            check_eq("out_val", 64'(out_val), 64'(m_oval));
            check_eq("out_msg", 64'(out_msg), 64'(m_omsg));
            check_eq("xfer_count", 64'(xfer_count), 64'(m_cnt));
        end
        reset = rst_n; in_val = v; in_msg = msgs; in_done = d; out_rdy = ordy;
        #1;
        g   = pick(v);
        can = !m_oval || ordy;
        rdy_exp = '0;
        if (rst_n && can && g >= 0) rdy_exp[g] = 1'b1;
        check_eq("in_rdy", 64'(in_rdy), 64'(rdy_exp));
        check_eq("all_done", 64'(all_done), 64'(rst_n && (&d) && !m_oval));
        g_out = (rdy_exp != '0) ? g : -1;
        if (!rst_n) begin
            m_ptr = 0; m_owner = 0; m_burst = 0; m_locked = 0;
            m_oval = 0; m_omsg = '0; m_cnt = 0; m_known = 1;
        end else begin
            if (m_oval && ordy) m_cnt++;
            if (rdy_exp != '0) begin
                m_oval = 1;
                m_omsg = {2'(g), msgs[g*W +: W]};
                n = (m_locked && g == m_owner) ? m_burst + 1 : 1;
                if (n == BURST) begin
                    m_locked = 0; m_ptr = (g + 1) % N; m_burst = 0;
                end else begin
                    m_locked = 1; m_owner = g; m_burst = n;
                end
            end else begin
                if (m_oval && ordy) m_oval = 0;
                if (m_locked && !v[m_owner]) begin
                    m_locked = 0; m_ptr = (m_owner + 1) % N; m_burst = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    localparam logic [N*W-1:0] PAY_A = 32'hA3A2A1A0;

    initial begin
        int g;
        int rem [N];
        logic [N-1:0] v, d;
        bit finished;
        m_known = 0;
        reset = 1'b0; in_val = '0; in_msg = '0; in_done = '0; out_rdy = 1'b0;
        @(negedge clk);

        // Reset held with every source valid and done.
        repeat (2) step(0, 4'hF, PAY_A, 4'hF, 1, g);

        // All valid, sink always ready: bursts rotate 0,1,2,3.
        repeat (18) step(1, 4'hF, PAY_A, 4'h0, 1, g);

        // Requesters 0 and 2 only, then 0 drops after two grants.
        repeat (10) step(1, 4'b0101, PAY_A, 4'h0, 1, g);
        step(0, 4'b0101, PAY_A, 4'h0, 1, g);
        repeat (2) step(1, 4'b0101, PAY_A, 4'h0, 1, g);
        repeat (4) step(1, 4'b0100, PAY_A, 4'h0, 1, g);

        // Backpressure with {1,0x55} buffered.
        step(1, 4'b0010, 32'h00005500, 4'h0, 1, g);
        repeat (3) step(1, 4'hF, PAY_A, 4'h0, 0, g);
        repeat (6) step(1, 4'hF, PAY_A, 4'h0, 1, g);

        // Random traffic with occasional reset.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 63) != 0), 4'($urandom_range(0, 15)), $urandom,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), g);
        end

        // Each source sends three messages then raises done.
        repeat (2) step(0, 4'h0, PAY_A, 4'h0, 1, g);
        for (int i = 0; i < N; i++) rem[i] = 3;
        finished = 0;
        for (int c = 0; c < 200 && !finished; c++) begin
            v = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                v[i] = (rem[i] > 0) && ($urandom_range(0, 1) == 1);
                d[i] = (rem[i] == 0);
            end
            step(1, v, $urandom, d, ($urandom_range(0, 3) != 0), g);
            if (g >= 0) rem[g]--;
            finished = (rem[0] == 0 && rem[1] == 0 && rem[2] == 0 && rem[3] == 0 && !m_oval);
        end
        check_eq("done_drain", 64'(finished), 64'(1));
        step(1, 4'h0, PAY_A, 4'hF, 1, g);
        check_eq("done_count", 64'(xfer_count), 64'(12));
        check_eq("done_flag", 64'(all_done), 64'(1));

        // Reset while a message is buffered: it is never delivered.
        step(1, 4'hF, PAY_A, 4'h0, 0, g);
        step(0, 4'hF, PAY_A, 4'h0, 1, g);
        check_eq("rst_mid_val", 64'(out_val), 64'(0));
        check_eq("rst_mid_cnt", 64'(xfer_count), 64'(0));
        repeat (3) step(1, 4'h0, PAY_A, 4'h0, 1, g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vc_test_src_arbiter.md
# vc_test_src_arbiter

Round-robin arbiter that shares one val/rdy sink among `p_num_reqs` test sources. It has bounded-burst grant locking and a one-entry registered output stage. Each forwarded message is tagged with the index of the source that sent it. The block sits between a bank of test sources and a single sink or DUT input port in multi-requester test harnesses. It also reports when every source has drained.

## Interface

Parameters:
- `p_msg_nbits`, 8, payload width per requester
- `p_num_reqs`, 4, number of requesters (≥2)
- `p_max_burst`, 4, maximum consecutive transfers granted to one requester before forced rotation (≥1)
- Derived: `c_tag_nbits` = $clog2(p_num_reqs)

Ports:
- `clk`  input  1  clock; all state updates on posedge
- `reset`  input  1  synchronous, active-low: state resets on a posedge where `reset`==0
- `in_val`  input  p_num_reqs  per-requester valid
- `in_rdy`  output  p_num_reqs  per-requester ready
- `in_msg`  input  p_num_reqs*p_msg_nbits  flattened payloads; requester i occupies bits [i*p_msg_nbits +: p_msg_nbits]
- `in_done`  input  p_num_reqs  per-requester done flags
- `out_val`  output  1  output valid (registered)
- `out_rdy`  input  1  output ready
- `out_msg`  output  c_tag_nbits+p_msg_nbits  {tag, payload} (registered)
- `xfer_count`  output  32  number of completed output transfers; wraps modulo 2^32
- `all_done`  output  1  all sources done and output stage empty

## Operation

Output stage:
- The output stage is a one-entry register holding `out_val` and `out_msg`.
- `can_accept` = !out_val || out_rdy, so the stage passes through when the entry drains in the same cycle.

Grant (combinational) from state {`ptr`, `locked`, `owner`, `burst_cnt`}:
- If `locked` and `in_val[owner]`: grant goes to `owner`.
- Otherwise: grant goes to the first i with `in_val[i]`=1, scanning from `ptr` upward modulo p_num_reqs (when `locked`, the scan starts at owner+1).
- No valid requester means no grant.

Ready and transfer:
- `in_rdy[i]` = grant[i] && can_accept && reset. At most one bit of `in_rdy` is high in any cycle.
- An input transfer occurs when `in_val[g]` && `in_rdy[g]` for the granted index g.
- On an input transfer, the output register loads {g, payload_g} and `out_val` is set to 1.
- Otherwise, if out_val && out_rdy, `out_val` is cleared to 0.
- The output register holds its contents while out_val && !out_rdy.

Burst and lock update on an input transfer from g:
- Let n = (`locked` && g==`owner`) ? burst_cnt+1 : 1.
- If n == p_max_burst: `locked` <= 0, `ptr` <= g+1 mod N, `burst_cnt` <= 0.
- Else: `locked` <= 1, `owner` <= g, `burst_cnt` <= n.

Lock release without a transfer:
- If `locked` && !in_val[owner] with no transfer: `locked` <= 0, `ptr` <= owner+1 mod N, `burst_cnt` <= 0.

Setting p_max_burst=1 gives pure round-robin: `locked` never sets.

Counters and done:
- `xfer_count` increments on every out_val && out_rdy cycle.
- `all_done` = reset && (&in_done) && !out_val.

## Timing

- Latency is 1 cycle: a message accepted at edge k appears on `out_msg` with `out_val`=1 after edge k.
- Throughput is 1 msg/cycle while `out_rdy`=1.
- Backpressure: while out_val && !out_rdy, `in_rdy` is all-zero and `out_msg` is stable.
- Reset values (posedge with reset==0): out_val=0, out_msg=0, ptr=0, locked=0, owner=0, burst_cnt=0, xfer_count=0.
- While reset==0: `in_rdy`=0 and `all_done`=0.
- Reset asserted mid-operation discards the buffered message. No transfer completes on that edge.
- Arbiter state updates only on an input transfer or a lock release. A held `out_rdy`=0 does not rotate `ptr`.
- Pointer wrap: ptr = p_num_reqs-1 followed by a transfer from that requester gives ptr=0.
- Simultaneous drain and load on one edge: `out_val` stays 1 with the new message, and `xfer_count` increments once.

## Test plan

- Reset: hold reset=0 for 2 cycles with all in_val=1 -> in_rdy=0, out_val=0, xfer_count=0; after release, first grant goes to requester 0.
- Pure round-robin (p_max_burst=1, N=4): all in_val=1, out_rdy=1, payloads 0xA0..0xA3 -> out_msg tags 0,1,2,3,0,… on consecutive cycles, one message per cycle, xfer_count=8 after 8 transfers.
- Burst lock (p_max_burst=4): requesters 0 and 2 always valid -> tags 0,0,0,0,2,2,2,2,0,…; requester 0 drops val after 2 transfers -> lock releases and the next grant goes to 2 that cycle.
- Backpressure: out_rdy=0 for 3 cycles with message {1,0x55} buffered -> out_msg holds {1,0x55}, in_rdy=0, ptr unchanged; out_rdy=1 then passes through one new message per cycle.
- Done: each of 4 sources sends 3 messages then raises in_done -> all_done rises on the cycle after the final out_val && out_rdy, and xfer_count=12.
- Reset mid-stream: reset=0 while out_val=1 -> out_val=0 the next cycle, the buffered message is never delivered, and xfer_count=0.
